// File: rtl/bin_target_locate.sv
// Per-frame foreground statistics (count, bounding box, centroid) for a 1-bit pixel stream.
// Optional macro CENTROID_ROUND_EN: round-to-nearest centroid instead of truncation.
module bin_target_locate #(
    parameter logic [10:0] IMG_HDISP  = 11'd1280,
    parameter logic [10:0] IMG_VDISP  = 11'd720,
    parameter logic [19:0] MIN_PIXELS = 20'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_img_vsync,
    input  logic        per_img_href,
    input  logic        per_img_bit,
    output logic        result_valid,
    output logic        target_found,
    output logic [19:0] pixel_cnt,
    output logic [10:0] box_xmin,
    output logic [10:0] box_xmax,
    output logic [10:0] box_ymin,
    output logic [10:0] box_ymax,
    output logic [10:0] cent_x,
    output logic [10:0] cent_y
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DIV   = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    // One restoring-division step: returns {remainder, shifted dividend/quotient}.
    function automatic logic [51:0] div_step(input logic [19:0] rem, input logic [31:0] dq,
                                             input logic [19:0] dsr);
        logic [20:0] sh;
        logic [19:0] diff;
        sh   = {rem, dq[31]};
        diff = sh[19:0] - dsr;
        if (sh >= {1'b0, dsr}) begin
            return {diff, dq[30:0], 1'b1};
        end else begin
            return {sh[19:0], dq[30:0], 1'b0};
        end
    endfunction

    logic        vsync_d_r, href_d_r, armed_r, frame_active_r, frame_end_r;
    logic        rise_s, fall_s, href_rise_s, href_fall_s, pix_s;
    logic [10:0] x_r, y_r, x_cur_s, y_cur_s;

    logic [19:0] cnt_r, cnt_b_s, cnt_n_s;
    logic [31:0] sum_x_r, sum_y_r, sum_x_b_s, sum_y_b_s, sum_x_n_s, sum_y_n_s, bias_s;
    logic [10:0] xmin_r, xmax_r, ymin_r, ymax_r;
    logic [10:0] xmin_b_s, xmax_b_s, ymin_b_s, ymax_b_s;
    logic [10:0] xmin_n_s, xmax_n_s, ymin_n_s, ymax_n_s;

    state_t      state_r, state_n_s;
    logic        snap_s, div_en_s, load_s;
    logic [19:0] dsr_r, rem_x_r, rem_y_r;
    logic [31:0] dq_x_r, dq_y_r;
    logic [5:0]  iter_r;
    logic [10:0] sxmin_r, sxmax_r, symin_r, symax_r;

    // Frame/line edge detection and pixel coordinate generation.
    always_comb begin
        rise_s      = per_img_vsync & ~vsync_d_r & armed_r;
        fall_s      = ~per_img_vsync & vsync_d_r & frame_active_r;
        href_rise_s = per_img_href & ~href_d_r;
        href_fall_s = ~per_img_href & href_d_r;
        x_cur_s     = href_rise_s ? 11'd0 : x_r;
        y_cur_s     = rise_s ? 11'd0 : y_r;
        pix_s       = per_img_vsync & per_img_href & per_img_bit & (frame_active_r | rise_s)
                      & (x_cur_s < IMG_HDISP) & (y_cur_s < IMG_VDISP);
    end

    // Registered sync signals; armed_r blocks a frame already running when reset releases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d_r      <= 1'b0;
            href_d_r       <= 1'b0;
            armed_r        <= 1'b0;
            frame_active_r <= 1'b0;
            frame_end_r    <= 1'b0;
            x_r            <= 11'd0;
            y_r            <= 11'd0;
        end else begin
            vsync_d_r      <= per_img_vsync;
            href_d_r       <= per_img_href;
            armed_r        <= armed_r | ~per_img_vsync;
            frame_active_r <= rise_s | (frame_active_r & ~fall_s);
            frame_end_r    <= fall_s;
            x_r            <= per_img_href ? sat_inc(x_cur_s) : x_r;
            y_r            <= rise_s ? 11'd0 : (href_fall_s ? sat_inc(y_r) : y_r);
        end
    end

    // Accumulator next values; frame start reinitialises before the same-cycle pixel.
    always_comb begin
        cnt_b_s   = rise_s ? 20'd0 : cnt_r;
        sum_x_b_s = rise_s ? 32'd0 : sum_x_r;
        sum_y_b_s = rise_s ? 32'd0 : sum_y_r;
        xmin_b_s  = rise_s ? 11'h7FF : xmin_r;
        xmax_b_s  = rise_s ? 11'd0 : xmax_r;
        ymin_b_s  = rise_s ? 11'h7FF : ymin_r;
        ymax_b_s  = rise_s ? 11'd0 : ymax_r;
        cnt_n_s   = cnt_b_s;
        sum_x_n_s = sum_x_b_s;
        sum_y_n_s = sum_y_b_s;
        xmin_n_s  = xmin_b_s;
        xmax_n_s  = xmax_b_s;
        ymin_n_s  = ymin_b_s;
        ymax_n_s  = ymax_b_s;
        if (pix_s) begin
            cnt_n_s   = cnt_b_s + 20'd1;
            sum_x_n_s = sum_x_b_s + {21'd0, x_cur_s};
            sum_y_n_s = sum_y_b_s + {21'd0, y_cur_s};
            xmin_n_s  = (x_cur_s < xmin_b_s) ? x_cur_s : xmin_b_s;
            xmax_n_s  = (x_cur_s > xmax_b_s) ? x_cur_s : xmax_b_s;
            ymin_n_s  = (y_cur_s < ymin_b_s) ? y_cur_s : ymin_b_s;
            ymax_n_s  = (y_cur_s > ymax_b_s) ? y_cur_s : ymax_b_s;
        end else begin
            cnt_n_s   = cnt_b_s;
        end
`ifdef CENTROID_ROUND_EN
        bias_s = {13'd0, cnt_r[19:1]};
`else
        bias_s = 32'd0;
`endif
    end

    // Accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= 20'd0;
            sum_x_r <= 32'd0;
            sum_y_r <= 32'd0;
            xmin_r  <= 11'd0;
            xmax_r  <= 11'd0;
            ymin_r  <= 11'd0;
            ymax_r  <= 11'd0;
        end else begin
            cnt_r   <= cnt_n_s;
            sum_x_r <= sum_x_n_s;
            sum_y_r <= sum_y_n_s;
            xmin_r  <= xmin_n_s;
            xmax_r  <= xmax_n_s;
            ymin_r  <= ymin_n_s;
            ymax_r  <= ymax_n_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // FSM next state; a frame ending outside ACCUM is dropped.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE:    state_n_s = (rise_s | frame_active_r) ? ACCUM : IDLE;
            ACCUM:   state_n_s = frame_end_r ? ((cnt_r == 20'd0) ? DONE : DIV) : ACCUM;
            DIV:     state_n_s = (iter_r == 6'd31) ? DONE : DIV;
            DONE:    state_n_s = (rise_s | frame_active_r) ? ACCUM : IDLE;
            default: state_n_s = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        snap_s   = (state_r == ACCUM) & frame_end_r;
        div_en_s = (state_r == DIV);
        load_s   = (state_r == DONE);
    end

    // Snapshot plus first division step, then 31 more steps in DIV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsr_r   <= 20'd0;
            rem_x_r <= 20'd0;
            rem_y_r <= 20'd0;
            dq_x_r  <= 32'd0;
            dq_y_r  <= 32'd0;
            iter_r  <= 6'd0;
            sxmin_r <= 11'd0;
            sxmax_r <= 11'd0;
            symin_r <= 11'd0;
            symax_r <= 11'd0;
        end else if (snap_s) begin
            dsr_r              <= cnt_r;
            {rem_x_r, dq_x_r}  <= div_step(20'd0, sum_x_r + bias_s, cnt_r);
            {rem_y_r, dq_y_r}  <= div_step(20'd0, sum_y_r + bias_s, cnt_r);
            iter_r             <= 6'd1;
            sxmin_r            <= xmin_r;
            sxmax_r            <= xmax_r;
            symin_r            <= ymin_r;
            symax_r            <= ymax_r;
        end else if (div_en_s) begin
            {rem_x_r, dq_x_r}  <= div_step(rem_x_r, dq_x_r, dsr_r);
            {rem_y_r, dq_y_r}  <= div_step(rem_y_r, dq_y_r, dsr_r);
            iter_r             <= iter_r + 6'd1;
        end else begin
            iter_r             <= iter_r;
        end
    end

    // Result set: loaded together in DONE and held until the next pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_valid <= 1'b0;
            target_found <= 1'b0;
            pixel_cnt    <= 20'd0;
            box_xmin     <= 11'd0;
            box_xmax     <= 11'd0;
            box_ymin     <= 11'd0;
            box_ymax     <= 11'd0;
            cent_x       <= 11'd0;
            cent_y       <= 11'd0;
        end else if (load_s) begin
            result_valid <= 1'b1;
            pixel_cnt    <= dsr_r;
            if (dsr_r == 20'd0) begin
                target_found <= 1'b0;
                box_xmin     <= 11'd0;
                box_xmax     <= 11'd0;
                box_ymin     <= 11'd0;
                box_ymax     <= 11'd0;
                cent_x       <= 11'd0;
                cent_y       <= 11'd0;
            end else begin
                target_found <= (dsr_r >= MIN_PIXELS);
                box_xmin     <= sxmin_r;
                box_xmax     <= sxmax_r;
                box_ymin     <= symin_r;
                box_ymax     <= symax_r;
                cent_x       <= dq_x_r[10:0];
                cent_y       <= dq_y_r[10:0];
            end
        end else begin
            result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bin_target_locate.sv
// Scoreboard bench for bin_target_locate: frames are generated from rectangle/noise rules,
// a reference model derives expected results, and a monitor checks each result pulse.
module tb_bin_target_locate;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic        pbit = 1'b0;
    logic        result_valid, target_found;
    logic [19:0] pixel_cnt;
    logic [10:0] box_xmin, box_xmax, box_ymin, box_ymax, cent_x, cent_y;

    bin_target_locate dut (
        .clk(clk), .rst_n(rst_n),
        .per_img_vsync(vsync), .per_img_href(href), .per_img_bit(pbit),
        .result_valid(result_valid), .target_found(target_found), .pixel_cnt(pixel_cnt),
        .box_xmin(box_xmin), .box_xmax(box_xmax), .box_ymin(box_ymin), .box_ymax(box_ymax),
        .cent_x(cent_x), .cent_y(cent_y)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int cnt, xmin, xmax, ymin, ymax, cx, cy, found, lat, fall_cyc;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    // Frame description: one rectangle, one optional long line with a foreground tail, noise.
    int r_x0, r_x1, r_y0, r_y1;
    int base_w, extra_w, noise_pct, long_y, long_w, long_x0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp_v, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cfg();
        r_x0 = -1; r_x1 = -2; r_y0 = -1; r_y1 = -2;
        base_w = 3; extra_w = 2; noise_pct = 0;
        long_y = -1; long_w = 0; long_x0 = 99999;
    endtask

    task automatic set_rect(input int x0, input int x1, input int y0, input int y1);
        r_x0 = x0; r_x1 = x1; r_y0 = y0; r_y1 = y1;
    endtask

    function automatic bit fg(input int x, input int y);
        if (x >= r_x0 && x <= r_x1 && y >= r_y0 && y <= r_y1) return 1'b1;
        if (y == long_y && x >= long_x0) return 1'b1;
        if (noise_pct > 0 && int'($urandom_range(99)) < noise_pct) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_frame(input int nlines, input bit push, input bit end_in_line,
                               input int rst_line);
        int     cnt, xmn, xmx, ymn, ymx;
        longint sx, sy, bias;
        exp_t   e;
        cnt = 0; sx = 0; sy = 0; xmn = 2047; xmx = 0; ymn = 2047; ymx = 0;
        vsync = 1'b1;
        tick();
        tick();
        for (int y = 0; y < nlines; y++) begin
            int w;
            if (y == rst_line) begin
                rst_n = 1'b0;
                tick();
                tick();
                rst_n = 1'b1;
            end
            w = (y == long_y) ? long_w : ((y >= r_y0 && y <= r_y1) ? r_x1 + 1 + extra_w : base_w);
            for (int x = 0; x < w; x++) begin
                bit b;
                b = fg(x, y);
                href = 1'b1;
                pbit = b;
                if (b && x < 1280 && y < 720) begin
                    cnt++; sx += x; sy += y;
                    if (x < xmn) xmn = x;
                    if (x > xmx) xmx = x;
                    if (y < ymn) ymn = y;
                    if (y > ymx) ymx = y;
                end
                tick();
            end
            if (!(end_in_line && y == nlines - 1)) begin
                href = 1'b0;
                pbit = 1'b0;
                tick();
            end
        end
        pbit = 1'b0;
        vsync = 1'b0;
        e.fall_cyc = cyc + 1;
        tick();
        href = 1'b0;
        if (push) begin
            e.cnt = cnt;
            if (cnt == 0) begin
                e.xmin = 0; e.xmax = 0; e.ymin = 0; e.ymax = 0;
                e.cx = 0; e.cy = 0; e.found = 0; e.lat = 2;
            end else begin
`ifdef CENTROID_ROUND_EN
                bias = cnt / 2;
`else
                bias = 0;
`endif
                e.xmin = xmn; e.xmax = xmx; e.ymin = ymn; e.ymax = ymx;
                e.cx = int'((sx + bias) / cnt);
                e.cy = int'((sy + bias) / cnt);
                e.found = (cnt >= 16) ? 1 : 0;
                e.lat = 33;
            end
            sbq.push_back(e);
        end
    endtask

    task automatic rand_setup(output int nlines);
        r_x0 = $urandom_range(250);
        r_x1 = r_x0 + $urandom_range(19);
        r_y0 = $urandom_range(30);
        r_y1 = r_y0 + $urandom_range(9);
        noise_pct = $urandom_range(4);
        base_w = 1 + $urandom_range(39);
        nlines = r_y1 + 1 + $urandom_range(5);
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_valid", int'(result_valid), 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("latency", cyc - mon_e.fall_cyc, mon_e.lat);
                chk("pixel_cnt", int'(pixel_cnt), mon_e.cnt);
                chk("target_found", int'(target_found), mon_e.found);
                chk("box_xmin", int'(box_xmin), mon_e.xmin);
                chk("box_xmax", int'(box_xmax), mon_e.xmax);
                chk("box_ymin", int'(box_ymin), mon_e.ymin);
                chk("box_ymax", int'(box_ymax), mon_e.ymax);
                chk("cent_x", int'(cent_x), mon_e.cx);
                chk("cent_y", int'(cent_y), mon_e.cy);
            end
        end
    end

    initial begin
        int nl;
        clear_cfg();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("reset_valid", int'(result_valid), 0);
        chk("reset_pixel_cnt", int'(pixel_cnt), 0);
        chk("reset_box_xmin", int'(box_xmin), 0);
        chk("reset_cent_x", int'(cent_x), 0);
        chk("reset_found", int'(target_found), 0);

        // 3x3 block, below the found threshold.
        set_rect(100, 102, 50, 52);
        drive_frame(53, 1'b1, 1'b0, -1);
        repeat (60) tick();

        // 10x10 square: half-pixel centroid.
        set_rect(200, 209, 300, 309);
        drive_frame(310, 1'b1, 1'b0, -1);
        repeat (60) tick();

        // Empty frame: short zero-count path.
        clear_cfg();
        drive_frame(10, 1'b1, 1'b0, -1);
        repeat (60) tick();

        // Last column, over-long line, rows past the last active line, vsync falls mid-line.
        set_rect(10, 12, 719, 721);
        long_y = 5; long_w = 1300; long_x0 = 1275;
        drive_frame(725, 1'b1, 1'b1, -1);
        clear_cfg();
        repeat (60) tick();

        // Back-to-back frames with a short vertical blank.
        set_rect(0, 3, 0, 3);
        drive_frame(4, 1'b1, 1'b0, -1);
        repeat (3) tick();
        set_rect(1000, 1003, 700, 703);
        drive_frame(704, 1'b1, 1'b0, -1);
        clear_cfg();
        repeat (60) tick();

        // Reset in the middle of the division: no pulse, outputs cleared.
        set_rect(20, 29, 5, 9);
        drive_frame(12, 1'b0, 1'b0, -1);
        repeat (11) tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("div_rst_valid", int'(result_valid), 0);
        chk("div_rst_pixel_cnt", int'(pixel_cnt), 0);
        chk("div_rst_box_xmax", int'(box_xmax), 0);
        chk("div_rst_cent_y", int'(cent_y), 0);
        repeat (60) tick();
        rand_setup(nl);
        drive_frame(nl, 1'b1, 1'b0, -1);
        repeat (60) tick();

        // Reset inside a frame: that frame is ignored, the next one is processed.
        set_rect(30, 40, 2, 6);
        drive_frame(20, 1'b0, 1'b0, 8);
        repeat (60) tick();
        chk("frame_rst_pixel_cnt", int'(pixel_cnt), 0);
        rand_setup(nl);
        drive_frame(nl, 1'b1, 1'b0, -1);
        repeat (60) tick();

        // Randomized frames.
        for (int i = 0; i < 6; i++) begin
            rand_setup(nl);
            drive_frame(nl, 1'b1, 1'b0, -1);
            repeat (40) tick();
        end

        for (int i = 0; i < 200 && sbq.size() != 0; i++) tick();
        chk("pending_results", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
